// File: rtl/irq_ctrl.sv
// irq_ctrl: eight-source priority interrupt controller for the AVR-style core.
// Sources latch on rising edges into PENDING. ENABLE masks them, and bit 0 has
// the highest priority. One vector at a time is presented to the core over an
// int_req / int_ack handshake, and reti retires in-service levels.
// Optional build macro: IRQ_NESTING_EN allows higher-priority sources to preempt
// a running handler. Without it the controller is strictly single-level.
module irq_ctrl #(
    parameter logic [15:0] VECTOR_BASE = 16'd2,
    parameter logic [15:0] VECTOR_STEP = 16'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  irq_in,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  cfg_rdata,
    output logic        int_req,
    output logic [15:0] int_vector,
    input  logic        int_ack,
    input  logic        reti
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  enable_q, enable_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  inservice_q, inservice_d;
    logic [7:0]  irq_prev_q, irq_prev_d;

    logic [7:0]  edges;
    logic [7:0]  cand;
    logic [2:0]  cand_sel;
    logic [7:0]  w1c_mask;
    logic [7:0]  sel_mask;
    logic [7:0]  pend_after_cfg;
    logic        ack_hit;
    logic        reti_hit;
    logic        preempt_ok;

    // Index of the lowest set bit; callers only use it when the vector is nonzero.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    // Isolate the lowest set bit as a one-hot mask.
    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Edge detection, register writes, pending and in-service next values.
    always_comb begin
        irq_prev_d     = irq_in;
        edges          = irq_in & ~irq_prev_q;
        cand           = pending_q & enable_q;
        cand_sel       = lowest_idx(cand);
        w1c_mask       = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 8'h00;
        enable_d       = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : enable_q;
        sel_mask       = 8'b1 << sel_q;
        ack_hit        = (state_q == ST_REQ) && int_ack;
        reti_hit       = reti && (inservice_q != 8'h00);
        // A fresh edge always overrides a clear on the same bit.
        pend_after_cfg = (pending_q & ~w1c_mask) | edges;
        pending_d      = (pending_q & ~w1c_mask & ~(ack_hit ? sel_mask : 8'h00)) | edges;
        inservice_d    = inservice_q;
        if (reti_hit) inservice_d = inservice_q & ~lowest_bit(inservice_q);
        if (ack_hit)  inservice_d = inservice_d | sel_mask;
`ifdef IRQ_NESTING_EN
        preempt_ok     = (cand != 8'h00) && (cand_sel < lowest_idx(inservice_q));
`else
        preempt_ok     = 1'b0;
`endif
    end

    // Request FSM: choose, hold, withdraw or retire the presented vector.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (cand != 8'h00 && inservice_q == 8'h00) begin
                    state_d = ST_REQ;
                    sel_d   = cand_sel;
                end
            end
            ST_REQ: begin
                if (ack_hit) begin
                    state_d = ST_SVC;
                end else if (!(pend_after_cfg[sel_q] && enable_d[sel_q])) begin
                    // A withdrawn nested request falls back to the handler still running.
                    state_d = (inservice_d != 8'h00) ? ST_SVC : ST_IDLE;
                end
            end
            ST_SVC: begin
                if (reti_hit) begin
                    if (inservice_d == 8'h00) state_d = ST_IDLE;
                end else if (preempt_ok) begin
                    state_d = ST_REQ;
                    sel_d   = cand_sel;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-window read mux and core-facing outputs.
    always_comb begin
        int_req    = (state_q == ST_REQ);
        int_vector = VECTOR_BASE + VECTOR_STEP * {13'd0, sel_q};
        case (cfg_addr)
            2'd0:    cfg_rdata = enable_q;
            2'd1:    cfg_rdata = pending_q;
            2'd2:    cfg_rdata = inservice_q;
            default: cfg_rdata = {4'd0, sel_q, int_req};
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= 3'd0;
            enable_q    <= 8'h00;
            pending_q   <= 8'h00;
            inservice_q <= 8'h00;
            irq_prev_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            irq_prev_q  <= irq_prev_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run against an
// event-level reference model of the interrupt controller.
module tb_irq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_ack;
    logic        reti;

    int errors = 0;
    int checks = 0;

    // Reference model: registers as bit sets, mode 0 idle / 1 requesting / 2 servicing.
    logic [7:0] m_en, m_pend, m_isv, m_prev;
    int         m_mode, m_sel;

    always #5 clock = ~clock;

    irq_ctrl #(.VECTOR_BASE(16'd2), .VECTOR_STEP(16'd2)) dut (
        .clock(clock), .reset(reset), .irq_in(irq_in), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack), .reti(reti)
    );

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_update(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                                input logic [7:0] wd, input logic ack, input logic rt, input logic rst);
        logic [7:0] rises, w1c, en_n, pend_n, isv_n, cand, ackmask, still;
        int mode_n, sel_n;
        if (rst) begin
            m_en = 0; m_pend = 0; m_isv = 0; m_prev = 0; m_mode = 0; m_sel = 0;
            return;
        end
        rises   = irq & ~m_prev;
        cand    = m_pend & m_en;
        w1c     = (we && addr == 2'd1) ? wd : 8'h00;
        en_n    = (we && addr == 2'd0) ? wd : m_en;
        ackmask = 8'h00;
        isv_n   = m_isv;
        mode_n  = m_mode;
        sel_n   = m_sel;
        still   = (m_pend & ~w1c) | rises;
        if (rt && m_isv != 0) isv_n[lowest(m_isv)] = 1'b0;
        if (m_mode == 1) begin
            if (ack) begin
                ackmask[m_sel] = 1'b1;
                isv_n[m_sel]   = 1'b1;
                mode_n         = 2;
            end else if (!(still[m_sel] && en_n[m_sel])) begin
                mode_n = (isv_n != 0) ? 2 : 0;
            end
        end else if (m_mode == 0) begin
            if (cand != 0 && m_isv == 0) begin
                mode_n = 1;
                sel_n  = lowest(cand);
            end
        end else begin
            if (rt && m_isv != 0) begin
                if (isv_n == 0) mode_n = 0;
            end
`ifdef IRQ_NESTING_EN
            else if (cand != 0 && lowest(cand) < lowest(m_isv)) begin
                mode_n = 1;
                sel_n  = lowest(cand);
            end
`endif
        end
        pend_n = (m_pend & ~w1c & ~ackmask) | rises;
        m_en = en_n; m_pend = pend_n; m_isv = isv_n; m_prev = irq; m_mode = mode_n; m_sel = sel_n;
    endtask

    task automatic step(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd, input logic ack, input logic rt);
        irq_in = irq; cfg_we = we; cfg_addr = addr; cfg_wdata = wd; int_ack = ack; reti = rt;
        @(posedge clock);
        model_update(irq, we, addr, wd, ack, rt, reset);
        #1;
        cfg_we = 1'b0; int_ack = 1'b0; reti = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        step(irq_in, 1'b1, addr, data, 1'b0, 1'b0);
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [7:0] data);
        cfg_addr = addr;
        #1;
        data = cfg_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset = 1'b1;
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", int_req); end
        checks++; if (int_vector !== 16'h0002) begin errors++; $display("[TB] FAIL reset_vector: got %h want 0002", int_vector); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h want 00", a, rd); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] rd;
        wr(2'd0, 8'h01);
        step(8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_req: got %b want 0", int_req); end
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("[TB] FAIL basic_pending: got %h want 01", rd); end
        step(8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req: got %b want 1", int_req); end
        checks++; if (int_vector !== 16'h0002) begin errors++; $display("[TB] FAIL basic_vector: got %h want 0002", int_vector); end
        read_reg(2'd3, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("[TB] FAIL basic_status: got %h want 01", rd); end
        step(8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_drop: got %b want 0", int_req); end
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("[TB] FAIL basic_inservice: got %h want 01", rd); end
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL basic_pending_clr: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL basic_reti: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got %b want 0", int_req); end
    endtask

    task automatic test_priority();
        logic [7:0] rd;
        wr(2'd0, 8'hFF);
        step(8'h20, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h20, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_vector !== 16'h000C || int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_first: req=%b vec=%h want 1/000C", int_req, int_vector); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_vector !== 16'h000C || int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_frozen: req=%b vec=%h want 1/000C", int_req, int_vector); end
        read_reg(2'd3, rd);
        checks++; if (rd !== 8'h0B) begin errors++; $display("[TB] FAIL prio_status: got %h want 0B", rd); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h20) begin errors++; $display("[TB] FAIL prio_inservice: got %h want 20", rd); end
`ifdef IRQ_NESTING_EN
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_vector !== 16'h0004 || int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_preempt: req=%b vec=%h want 1/0004", int_req, int_vector); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
`else
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_blocked: got %b want 0", int_req); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_reti_gap: got %b want 0", int_req); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_vector !== 16'h0004 || int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_next: req=%b vec=%h want 1/0004", int_req, int_vector); end
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
`endif
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL prio_unwound: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_mask_withdraw();
        logic [7:0] rd;
        wr(2'd0, 8'h00);
        step(8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_no_req: got %b want 0", int_req); end
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("[TB] FAIL mask_pending: got %h want 08", rd); end
        wr(2'd0, 8'h08);
        step(8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b1 || int_vector !== 16'h0008) begin errors++; $display("[TB] FAIL mask_enable_req: req=%b vec=%h want 1/0008", int_req, int_vector); end
        wr(2'd1, 8'h08);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL withdraw_req: got %b want 0", int_req); end
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL withdraw_pending: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        wr(2'd0, 8'h00);
    endtask

    task automatic test_collision();
        logic [7:0] rd;
        step(8'h04, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h04, 1'b1, 2'd1, 8'h04, 1'b0, 1'b0);
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h04) begin errors++; $display("[TB] FAIL collision_set_wins: got %h want 04", rd); end
        step(8'h04, 1'b1, 2'd1, 8'h04, 1'b0, 1'b0);
        read_reg(2'd1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL collision_w1c: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_nesting();
        logic [7:0] rd;
        wr(2'd0, 8'h11);
        step(8'h10, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h10, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b1 || int_vector !== 16'h000A) begin errors++; $display("[TB] FAIL nest_src4: req=%b vec=%h want 1/000A", int_req, int_vector); end
        step(8'h10, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
`ifdef IRQ_NESTING_EN
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b1 || int_vector !== 16'h0002) begin errors++; $display("[TB] FAIL nest_preempt: req=%b vec=%h want 1/0002", int_req, int_vector); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h11) begin errors++; $display("[TB] FAIL nest_inservice: got %h want 11", rd); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("[TB] FAIL nest_unwind1: got %h want 10", rd); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
`else
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL nest_blocked: got %b want 0", int_req); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL nest_reti_gap: got %b want 0", int_req); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (int_req !== 1'b1 || int_vector !== 16'h0002) begin errors++; $display("[TB] FAIL nest_after_reti: req=%b vec=%h want 1/0002", int_req, int_vector); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("[TB] FAIL nest_single: got %h want 01", rd); end
        step(8'h11, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
`endif
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL nest_unwound: got %h want 00", rd); end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_svc();
        logic [7:0] rd;
        wr(2'd0, 8'h02);
        step(8'h02, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h02, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(8'h02, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        step(8'h06, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_svc_req: got %b want 0", int_req); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL rst_svc_reg%0d: got %h want 00", a, rd); end
        end
        step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        read_reg(2'd2, rd);
        checks++; if (rd !== 8'h00 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_stray_reti: isv=%h req=%b want 00/0", rd, int_req); end
    endtask

    task automatic test_random();
        logic [7:0] rd, irq_n, wd;
        logic       we, ack, rt;
        logic [1:0] addr;
        for (int c = 0; c < 500; c++) begin
            irq_n = irq_in ^ 8'($urandom & $urandom & $urandom);
            we    = ($urandom_range(0, 5) == 0);
            addr  = 2'($urandom_range(0, 3));
            wd    = 8'($urandom);
            ack   = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rt    = (m_mode != 1) && ($urandom_range(0, 3) == 0);
            step(irq_n, we, addr, wd, ack, rt);
            checks++; if (int_req !== (m_mode == 1)) begin errors++; $display("[TB] FAIL rand_req c=%0d: got %b want %b", c, int_req, (m_mode == 1)); end
            if (m_mode == 1) begin
                checks++; if (int_vector !== 16'(2 + 2 * m_sel)) begin errors++; $display("[TB] FAIL rand_vector c=%0d: got %h want %h", c, int_vector, 16'(2 + 2 * m_sel)); end
            end
            read_reg(2'd0, rd);
            checks++; if (rd !== m_en) begin errors++; $display("[TB] FAIL rand_enable c=%0d: got %h want %h", c, rd, m_en); end
            read_reg(2'd1, rd);
            checks++; if (rd !== m_pend) begin errors++; $display("[TB] FAIL rand_pending c=%0d: got %h want %h", c, rd, m_pend); end
            read_reg(2'd2, rd);
            checks++; if (rd !== m_isv) begin errors++; $display("[TB] FAIL rand_inservice c=%0d: got %h want %h", c, rd, m_isv); end
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = 8'h00; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 8'h00; int_ack = 1'b0; reti = 1'b0;
        m_en = 0; m_pend = 0; m_isv = 0; m_prev = 0; m_mode = 0; m_sel = 0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_withdraw();
        test_collision();
        test_nesting();
        test_reset_mid_svc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Eight-source priority interrupt controller that schedules interrupt entry for the AVR-style core. It replaces the core's fixed single-vector timer interrupt: it latches source edges into pending bits, applies a per-source enable mask and fixed priority (bit 0 highest), and presents one vector at a time over a request/acknowledge handshake. The core's data-memory decoder reaches it through a small register window.

## Interface
- `VECTOR_BASE`, default 16'd2: word address of the source-0 vector.
- `VECTOR_STEP`, default 16'd2: word spacing between consecutive vectors.
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `irq_in` in 8: source lines; rising edge is the event.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 2: register select. 0 ENABLE (rw), 1 PENDING (read; write-1-to-clear), 2 INSERVICE (read-only), 3 STATUS (read-only: bit0 `int_req`, bits3:1 `sel`).
- `cfg_wdata` in 8: write data.
- `cfg_rdata` out 8: combinational read of the register at `cfg_addr`.
- `int_req` out 1: interrupt request to the core.
- `int_vector` out 16: vector for the current request; stable while `int_req` is high.
- `int_ack` in 1: core pulse at the vector-load cycle (PCH push).
- `reti` in 1: core pulse on RETI execution.

## Operation
- Edge detect: `irq_d <= irq_in`. Pending bit i sets when `irq_in[i] & ~irq_d[i]`.
- Candidate set is `pending & enable`. `sel` is the lowest set index of that set (3 bits).
- `int_vector = VECTOR_BASE + sel*VECTOR_STEP`, computed in 16 bits and wrapped mod 2^16.
- FSM states:
  - IDLE: `int_req` is 0. Go to REQ when a candidate exists and the eligibility rule passes. Latch `sel`.
  - REQ: `int_req` is 1 and `sel` is frozen. A higher-priority arrival does not change the vector.
    - On `int_ack`: clear `pending[sel]`, set `inservice[sel]`, go to SVC.
    - If `pending[sel]` or `enable[sel]` drops (by a cfg write) before ack: withdraw and return to IDLE.
  - SVC: `int_req` is 0.
    - On `reti`: clear the lowest set `inservice` bit. If `inservice` becomes 0, go to IDLE.
    - Under nesting (see Configuration), go to REQ on an eligible candidate.
- Eligibility rule: `inservice == 0`, and the nesting rule when it is compiled in.
- `reti` with `inservice == 0` is ignored. `int_ack` outside REQ is ignored.
- Register writes:
  - ENABLE: loaded from `cfg_wdata`.
  - PENDING: bits written as 1 are cleared.
  - INSERVICE and STATUS: writes are ignored.

## Timing
- Reset values: `int_req` 0, `int_vector` equal to `VECTOR_BASE`, `cfg_rdata` 0 (registers at reset), `enable` 0, `pending` 0, `inservice` 0, `irq_d` 0, state IDLE.
- Latency from a source rising edge at cycle N (sampled at edge N):
  - `pending` is set after edge N.
  - `int_req` is high after edge N+1 (state REQ).
  - Total: 2 cycles.
- `int_ack` sampled with `int_req` high: `int_req` is low the next cycle.
- A new request can assert no earlier than 1 cycle after the `reti` that empties `inservice`.
- Simultaneous events:
  - Edge set and W1C clear on the same bit: set wins.
  - `int_ack` and a withdrawing cfg write in the same cycle: ack wins.
  - `reti` and a new edge in the same cycle: both take effect.
- Reset mid-REQ or mid-SVC drops `int_req` the next cycle. All pending and in-service state is lost.

## Configuration
- `IRQ_NESTING_EN` defined:
  - In SVC, a candidate whose index is below the lowest set `inservice` bit is eligible and moves the FSM to REQ (preemption).
  - Ack sets an additional `inservice` bit.
  - Each `reti` unwinds one level.
- `IRQ_NESTING_EN` undefined:
  - Strictly single-level. No request while any `inservice` bit is set.
  - At most one `inservice` bit is ever set.

## Test plan
- Basic entry:
  - Stimulus: ENABLE=0x01, rising edge on `irq_in[0]`.
  - Response: `int_req` high 2 cycles later with vector 0x0002. After ack, INSERVICE=0x01, PENDING=0x00.
  - Then `reti`: INSERVICE=0x00, state IDLE.
- Priority and freeze:
  - Stimulus: ENABLE=0xFF, edge on src 5, then edge on src 1 while REQ is held.
  - Response: vector stays 0x000C until ack. After `reti`, the next request has vector 0x0004.
- Mask and withdraw:
  - Stimulus: edge on src 3 with ENABLE=0.
  - Response: PENDING=0x08 and no `int_req`.
  - Stimulus: set ENABLE=0x08.
  - Response: `int_req` high.
  - Stimulus: write PENDING=0x08.
  - Response: withdraw, `int_req` 0 the next cycle.
- Collision:
  - Stimulus: W1C of bit 2 in the same cycle as a src 2 edge.
  - Response: PENDING bit 2 stays 1.
- Nesting, run in both builds:
  - Stimulus: in service of src 4, edge on src 0.
  - With `IRQ_NESTING_EN`: request with vector 0x0002. After ack, INSERVICE=0x11. Two `reti`s return it to 0x00.
  - Without the macro: no request until the first `reti`.
- Reset mid-SVC:
  - Stimulus: assert `reset` for 1 cycle.
  - Response: all registers 0, `int_req` 0. A stray `reti` afterwards has no effect.
